uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format (data width, parity mode, stop-bit count) and a valid/ready write handshake. It sits between the system-side producer and the serial `out` pin. It is paced by the shared baud-rate strobe `enable_clk`, and is the next-generation replacement for the fixed 8E1 single-word transmitter.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `DEPTH`, 4: FIFO entries, power of two, ≥ 2.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable_clk` in 1: one-`clk`-wide baud strobe; one serial bit lasts one strobe period.
- `valid` in 1: producer offers `data_in`.
- `data_in` in DATA_W: word to send, LSB transmitted first.
- `ready` out 1: FIFO can accept a word. Equal to (`level` != DEPTH).
- `level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `tx_busy` out 1: high whenever the FSM is not in IDLE.
- `tx_done` out 1: one-`clk` pulse at the end of each frame's last stop bit.
- `out` out 1: serial line, idle high.

## Operation
- **Write:** a word enters the FIFO on any `clk` edge with `valid && ready`. When `ready` = 0 the write is dropped and the FIFO is unchanged. `ready` depends only on `level`, so a pop in the same cycle does not admit a write while full.
- **Frame format:** start (0), `data[0]`..`data[DATA_W-1]`, optional parity, then STOP_BITS × 1.
  - Even parity = ^data. Odd parity = ~^data.
  - Frame length F = 1 + DATA_W + (PARITY != 0) + STOP_BITS strobe periods.
- **FSM states:** IDLE, START, DATA, PAR, STOP. All transitions and all `out` updates occur only on `clk` edges where `enable_clk` = 1 ("ticks").
  - IDLE, tick, FIFO non-empty: pop head into the shift register, `out` ← 0, go to START.
  - IDLE, tick, FIFO empty: `out` stays 1.
  - START, tick: `out` ← `data[0]`, bit counter ← 0, go to DATA.
  - DATA, tick, counter < DATA_W-1: shift, `out` ← next bit, counter+1.
  - DATA, tick, counter = DATA_W-1: go to PAR with `out` ← parity if PARITY != 0; otherwise go to STOP with `out` ← 1.
  - PAR, tick: `out` ← 1, go to STOP, stop counter ← 0.
  - STOP, tick, stop counter < STOP_BITS-1: `out` stays 1, stop counter+1.
  - STOP, final tick: assert `tx_done`. If the FIFO is non-empty, pop, `out` ← 0 and go to START on the same tick (no idle gap). Otherwise go to IDLE with `out` = 1.
- **Parity capture:** parity is computed from the popped word and stored at pop time. `data_in` changes after the write do not affect it.
- **FIFO structure:** circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. `level` +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.

## Timing
- **Reset values (asynchronous, immediate):** `out` = 1, `tx_busy` = 0, `tx_done` = 0, `level` = 0, `ready` = 1, FSM = IDLE, pointers = 0.
- **Reset mid-frame:** the frame is abandoned, `out` returns high at once, and the FIFO is flushed.
- **Write-to-visibility latency:** a word written on edge N is visible to the FSM from edge N+1. A tick coincident with that write on an empty FIFO does not start a frame.
- **Start latency:** the start bit begins on the first tick after the word becomes visible, so worst case is one strobe period plus one `clk`.
- **Back-to-back frames:** with the FIFO non-empty, consecutive frames occupy exactly F ticks each with no idle bit.
- **`tx_done`:** high for exactly one `clk`, coincident with the final STOP tick edge.
- **Strobe independence:** `enable_clk` held low freezes the FSM and `out`, while FIFO writes continue.

## Test plan
- **8E1 single word:** DATA_W=8, PARITY=1, STOP_BITS=1, tick every 16 clk; write 0xA5 → `out` per tick 0,1,0,1,0,0,1,0,1,0,1 then idle 1. `tx_done` pulses once, `level` 1→0.
- **7O2 all-zero word:** DATA_W=7, PARITY=2, STOP_BITS=2; write 0x00 → 0,0,0,0,0,0,0,0,1,1,1, for F = 11 ticks, with the parity bit = 1.
- **Back-to-back:** 8N1; write 0x01, 0x80, 0xFF in three consecutive clk → 30 ticks with no idle bit between frames; `tx_done` pulses 3 times, 10 ticks apart.
- **FIFO full:** DEPTH=4, `enable_clk` held 0; assert `valid` for 6 clk with 0x10..0x15 → `ready` falls after the 4th write and `level` = 4. Releasing ticks transmits only 0x10..0x13 in order.
- **Write while full plus pop:** FIFO full, pop tick and `valid` in the same cycle → the write is rejected and `level` = 3 afterwards.
- **Reset mid-frame:** drop `rst_n` during the DATA bit 3 of 0x5A with 2 words queued → `out` = 1, `level` = 0, `tx_busy` = 0 immediately. After release no frame starts until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with integrated transmit FIFO and configurable frame format
module uart_tx_fifo #(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_clk,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_W);

    localparam bit                PAR_EN    = (PARITY != 0);
    localparam bit                PAR_ODD   = (PARITY == 2);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic              head_par;

    // Transmitter state
    state_t            state, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              par_q, par_n;
    logic [CNT_W-1:0]  bit_q, bit_n;
    logic              stop_q, stop_n;
    logic              out_n;
    logic              done_n;

    // ready depends only on occupancy, so a same-cycle pop never frees a slot early
    assign ready    = (level != FULL_LVL);
    assign empty    = (level == '0);
    assign push     = valid && ready;
    assign head     = mem[rd_ptr];
    assign head_par = PAR_ODD ? ~^head : ^head;
    assign tx_busy  = (state != S_IDLE);

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FIFO data array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Transmitter registers; reset abandons any frame and forces the line idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            out     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            par_q   <= par_n;
            bit_q   <= bit_n;
            stop_q  <= stop_n;
            out     <= out_n;
            tx_done <= done_n;
        end
    end

    // Next-state logic: everything advances only on baud ticks; parity is latched at pop
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        par_n   = par_q;
        bit_n   = bit_q;
        stop_n  = stop_q;
        out_n   = out;
        done_n  = 1'b0;
        pop     = 1'b0;
        if (enable_clk) begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        par_n   = head_par;
                        out_n   = 1'b0;
                        state_n = S_START;
                    end else begin
                        out_n   = 1'b1;
                    end
                end
                S_START: begin
                    out_n   = shift_q[0];
                    bit_n   = '0;
                    state_n = S_DATA;
                end
                S_DATA: begin
                    if (bit_q != LAST_BIT) begin
                        shift_n = shift_q >> 1;
                        out_n   = shift_q[1];
                        bit_n   = bit_q + 1'b1;
                    end else if (PAR_EN) begin
                        out_n   = par_q;
                        state_n = S_PAR;
                    end else begin
                        out_n   = 1'b1;
                        stop_n  = 1'b0;
                        state_n = S_STOP;
                    end
                end
                S_PAR: begin
                    out_n   = 1'b1;
                    stop_n  = 1'b0;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    if (stop_q != STOP_LAST) begin
                        stop_n = stop_q + 1'b1;
                    end else begin
                        done_n = 1'b1;
                        if (!empty) begin
                            // chain straight into the next start bit with no idle gap
                            pop     = 1'b1;
                            shift_n = head;
                            par_n   = head_par;
                            out_n   = 1'b0;
                            state_n = S_START;
                        end else begin
                            out_n   = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                end
                default: begin
                    out_n   = 1'b1;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int DW [3] = '{8, 7, 8};
    localparam int PM [3] = '{1, 2, 0};
    localparam int SB [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_clk;
    logic       v0, v1, v2;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;
    logic       ready_v [3];
    logic [2:0] lvl     [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       out_v   [3];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .enable_clk(enable_clk), .valid(v0), .data_in(din0),
        .ready(ready_v[0]), .level(lvl[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .out(out_v[0])
    );
    uart_tx_fifo #(.DATA_W(7), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .enable_clk(enable_clk), .valid(v1), .data_in(din1),
        .ready(ready_v[1]), .level(lvl[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .out(out_v[1])
    );
    uart_tx_fifo #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .enable_clk(enable_clk), .valid(v2), .data_in(din2),
        .ready(ready_v[2]), .level(lvl[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .out(out_v[2])
    );

    // Reference model: pending words, bits still to send for the current frame
    logic [8:0]  mq  [3][$];
    bit          eb  [3][$];
    bit          inf [3];
    bit          mo  [3];
    bit          md  [3];
    logic [31:0] rec [3];
    int          dcnt [3];
    int          gap;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_frame(input int i, input logic [8:0] w);
        bit p;
        p = ^w;
        if (PM[i] == 2) p = ~p;
        eb[i].push_back(1'b0);
        for (int b = 0; b < DW[i]; b++) eb[i].push_back(w[b]);
        if (PM[i] != 0) eb[i].push_back(p);
        for (int s = 0; s < SB[i]; s++) eb[i].push_back(1'b1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            eb[i].delete();
            inf[i] = 1'b0;
            mo[i]  = 1'b1;
            md[i]  = 1'b0;
        end
    endtask

    task automatic model_tick(input int i);
        md[i] = 1'b0;
        if (inf[i] && eb[i].size() == 0) begin
            md[i]  = 1'b1;
            inf[i] = 1'b0;
        end
        if (!inf[i] && mq[i].size() > 0) begin
            load_frame(i, mq[i].pop_front());
            inf[i] = 1'b1;
        end
        if (inf[i]) mo[i] = eb[i].pop_front();
        else        mo[i] = 1'b1;
    endtask

    // One clk cycle: optional tick, optional write to instance wi (-1 = none), then check all
    task automatic step(input bit tk, input int wi, input logic [8:0] w);
        bit         acc;
        logic [8:0] wm;
        acc = 1'b0;
        wm  = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("ready%0d", i), ready_v[i], (mq[i].size() != DEPTH));
        enable_clk = tk;
        if (wi >= 0) begin
            wm  = w & ((9'd1 << DW[wi]) - 9'd1);
            acc = (mq[wi].size() != DEPTH);
            case (wi)
                0: begin v0 = 1'b1; din0 = wm[7:0]; end
                1: begin v1 = 1'b1; din1 = wm[6:0]; end
                default: begin v2 = 1'b1; din2 = wm[7:0]; end
            endcase
        end
        @(posedge clk);
        #1;
        enable_clk = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (tk) model_tick(i);
            else    md[i] = 1'b0;
        end
        if (acc) mq[wi].push_back(wm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out%0d", i), out_v[i], mo[i]);
            chk($sformatf("done%0d", i), done_v[i], md[i]);
            chk($sformatf("busy%0d", i), busy_v[i], inf[i]);
            chk($sformatf("level%0d", i), lvl[i], mq[i].size());
            if (tk) begin
                rec[i]  = {rec[i][30:0], out_v[i]};
                dcnt[i] = dcnt[i] + (done_v[i] ? 1 : 0);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, -1, 9'h0);
            for (int g = 0; g < gap; g++) step(1'b0, -1, 9'h0);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        gap        = 3;
        rst_n      = 1'b0;
        enable_clk = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        din0 = '0; din1 = '0; din2 = '0;
        for (int i = 0; i < 3; i++) begin
            rec[i]  = '0;
            dcnt[i] = 0;
        end
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out%0d", i), out_v[i], 1'b1);
            chk($sformatf("rst_busy%0d", i), busy_v[i], 1'b0);
            chk($sformatf("rst_done%0d", i), done_v[i], 1'b0);
            chk($sformatf("rst_level%0d", i), lvl[i], 3'd0);
            chk($sformatf("rst_ready%0d", i), ready_v[i], 1'b1);
        end
        rst_n = 1'b1;

        // 8E1 single word 0xA5, tick every 16 clk
        gap = 15;
        step(1'b0, 0, 9'h0A5);
        ticks(12);
        chk("8e1_seq", rec[0][11:0], 12'b0101_0010_1011);
        chk("8e1_done", dcnt[0], 1);

        // 7O2 all-zero word
        gap = 3;
        step(1'b0, 1, 9'h000);
        ticks(12);
        chk("7o2_seq", rec[1][11:0], 12'h00F);
        chk("7o2_done", dcnt[1], 1);

        // write coincident with a tick on an empty FIFO must not start that tick
        step(1'b1, 0, 9'h03C);
        chk("coinc_busy", busy_v[0], 1'b0);
        ticks(13);

        // 8N1 back-to-back
        step(1'b0, 2, 9'h001);
        step(1'b0, 2, 9'h080);
        step(1'b0, 2, 9'h0FF);
        ticks(31);
        chk("b2b_seq", rec[2][30:0], 31'b0100000001_0000000011_0111111111_1);
        chk("b2b_done", dcnt[2], 3);

        // FIFO full with strobe held low, then write during a pop tick while full
        for (int k = 0; k < 6; k++) step(1'b0, 2, 9'h010 + 9'(k));
        chk("full_level", lvl[2], 3'd4);
        chk("full_ready", ready_v[2], 1'b0);
        step(1'b1, 2, 9'h016);
        chk("fullpop_level", lvl[2], 3'd3);
        ticks(42);

        // reset in the middle of DATA bit 3 of 0x5A with two words queued
        step(1'b0, 2, 9'h05A);
        step(1'b0, 2, 9'h011);
        step(1'b0, 2, 9'h022);
        ticks(5);
        chk("mid_bit3", out_v[2], 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", out_v[2], 1'b1);
        chk("midrst_level", lvl[2], 3'd0);
        chk("midrst_busy", busy_v[2], 1'b0);
        chk("midrst_ready", ready_v[2], 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(12);

        // randomized traffic against the model
        gap = 1;
        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 5));
            step(($urandom_range(0, 2) == 0), (r < 3) ? r : -1, 9'($urandom));
        end
        ticks(70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
